// File: rtl/mopshub_uplink_arbiter.sv
// Round-robin arbiter sharing the uplink e-link transmitter among 16 CAN
// receive channels, with per-transfer ack timeout and abort.
module mopshub_uplink_arbiter #(
   parameter int N_BUS   = 16,
   parameter int TIMEOUT = 4000,
   parameter int FRAME_W = 76
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [4:0]               n_buses,
   input  logic [N_BUS-1:0]         bus_req,
   input  logic [N_BUS*FRAME_W-1:0] bus_data,
   input  logic                     elink_ack,
   input  logic                     endwait_all,
   output logic [4:0]               can_rec_select,
   output logic [FRAME_W-1:0]       data_rec_uplink,
   output logic                     irq_elink_rec,
   output logic [N_BUS-1:0]         bus_pop,
   output logic                     timeout_err,
   output logic [4:0]               err_bus,
   output logic [15:0]              frame_cnt,
   output logic                     busy
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GRANT, WAIT, HOLD} state_t;

   state_t             state_q, state_d;
   logic [4:0]         sel_q, sel_d;
   logic [FRAME_W-1:0] data_q, data_d;
   logic               irq_q, irq_d;
   logic [N_BUS-1:0]   pop_q, pop_d;
   logic               terr_q, terr_d;
   logic [4:0]         err_bus_q, err_bus_d;
   logic [15:0]        cnt_q, cnt_d;
   logic [3:0]         lg_q, lg_d;
   logic [TW-1:0]      timer_q, timer_d;

   logic [3:0]         nb;
   logic [N_BUS-1:0]   elig;
   logic [FRAME_W-1:0] frames [N_BUS];
   logic               found;
   logic [3:0]         pick;
   logic [3:0]         cur;

   assign nb = n_buses[4] ? 4'd15 : n_buses[3:0];

   always_comb begin
      for (int i = 0; i < N_BUS; i++) begin
         elig[i]   = bus_req[i] && (5'(i) <= {1'b0, nb});
         frames[i] = bus_data[i*FRAME_W +: FRAME_W];
      end
   end

   // Scan starts just after the last grant; the last grant is tried last.
   always_comb begin
      cur   = (lg_q >= nb) ? 4'd0 : lg_q + 4'd1;
      found = 1'b0;
      pick  = 4'd0;
      for (int k = 0; k < N_BUS; k++) begin
         if (!found && elig[cur]) begin
            found = 1'b1;
            pick  = cur;
         end
         cur = (cur >= nb) ? 4'd0 : cur + 4'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      sel_d     = sel_q;
      data_d    = data_q;
      irq_d     = irq_q;
      pop_d     = '0;
      terr_d    = 1'b0;
      err_bus_d = err_bus_q;
      cnt_d     = cnt_q;
      lg_d      = lg_q;
      timer_d   = timer_q;
      case (state_q)
         IDLE: begin
            if (|elig) state_d = GRANT;
         end
         GRANT: begin
            if (found) begin
               sel_d   = {1'b0, pick};
               data_d  = frames[pick];
               irq_d   = 1'b1;
               timer_d = '0;
               state_d = WAIT;
            end else begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (elink_ack) begin
               irq_d             = 1'b0;
               pop_d[sel_q[3:0]] = 1'b1;
               cnt_d             = cnt_q + 16'd1;
               lg_d              = sel_q[3:0];
               state_d           = HOLD;
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               irq_d     = 1'b0;
               terr_d    = 1'b1;
               err_bus_d = sel_q;
               lg_d      = sel_q[3:0];
               state_d   = HOLD;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         HOLD: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Abort discards whatever this cycle decided, including an ack.
      if (endwait_all) begin
         state_d   = IDLE;
         sel_d     = sel_q;
         data_d    = data_q;
         irq_d     = 1'b0;
         pop_d     = '0;
         terr_d    = 1'b0;
         err_bus_d = err_bus_q;
         cnt_d     = cnt_q;
         lg_d      = lg_q;
         timer_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         data_q    <= '0;
         irq_q     <= 1'b0;
         pop_q     <= '0;
         terr_q    <= 1'b0;
         err_bus_q <= '0;
         cnt_q     <= '0;
         lg_q      <= nb;
         timer_q   <= '0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         data_q    <= data_d;
         irq_q     <= irq_d;
         pop_q     <= pop_d;
         terr_q    <= terr_d;
         err_bus_q <= err_bus_d;
         cnt_q     <= cnt_d;
         lg_q      <= lg_d;
         timer_q   <= timer_d;
      end
   end

   assign can_rec_select  = sel_q;
   assign data_rec_uplink = data_q;
   assign irq_elink_rec   = irq_q;
   assign bus_pop         = pop_q;
   assign timeout_err     = terr_q;
   assign err_bus         = err_bus_q;
   assign frame_cnt       = cnt_q;
   assign busy            = (state_q != IDLE);

endmodule
